// File: rtl/bcd_disp_pkg.sv
// ---- bcd_disp_pkg : shared digit index type, segment constants and BCD decode ----
// ---- rev 1.0 ----
`default_nettype none

package bcd_disp_pkg;

  typedef logic [2:0] dig_t;

  localparam dig_t DIG_FIRST = 3'd0;
  localparam dig_t DIG_LAST  = 3'd5;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [5:0] AN_OFF    = 6'h3F;

  typedef struct packed {
    logic [7:0] hours;
    logic [7:0] minutes;
    logic [7:0] seconds;
    logic       pm;
  } time_snap_t;

  // Segment order {g,f,e,d,c,b,a}, active-low; out-of-range nibbles show a dash.
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_DASH;
    endcase
    return seg;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_clock_display_scan_decode.sv
// ---- bcd_seg_decode : combinational nibble-to-segment decoder with blanking ----
// ---- rev 1.0 ----
`default_nettype none

module bcd_seg_decode
  import bcd_disp_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = bcd_to_seg(nibble);
    if (blank) seg_n = SEG_BLANK;
  end

endmodule

`default_nettype wire

// File: rtl/bcd_clock_display_scan.sv
// ---- bcd_clock_display_scan : six-digit multiplexed 7-seg scanner for a 12h BCD clock ----
// ---- optional DISP_DIM_EN adds the bright port and PWM digit gating ---- rev 1.0 ----
`default_nettype none

module bcd_clock_display_scan
  import bcd_disp_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] hours,
  input  logic [7:0] minutes,
  input  logic [7:0] seconds,
  input  logic       pm,
  output logic [6:0] seg_n,
  output logic       dp_n,
  output logic [5:0] an_n
`ifdef DISP_DIM_EN
  ,
  input  logic [2:0] bright
`endif
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic [DIV_W-1:0] div_nxt;
  dig_t             dig;
  dig_t             dig_nxt;
  time_snap_t       snap;
  time_snap_t       snap_nxt;
  logic             primed;
  logic             slot_end;

  logic [3:0]       nibble;
  logic             blank;
  logic [6:0]       seg_nxt;
  logic             dp_nxt;
  logic [5:0]       an_sel;
  logic [5:0]       an_nxt;
  logic             pwm_on;

  assign slot_end = (div_cnt == DIV_LAST);

  // Everything is computed for the state that will exist after this edge, so the
  // registered outputs line up with div_cnt/dig/snap in the same cycle.
  always_comb begin
    div_nxt  = slot_end ? '0 : div_cnt + DIV_W'(1);
    dig_nxt  = dig;
    if (slot_end) dig_nxt = (dig == DIG_LAST) ? DIG_FIRST : dig + 3'd1;
    snap_nxt = snap;
    if (!primed || (slot_end && dig == DIG_LAST)) begin
      snap_nxt = '{hours: hours, minutes: minutes, seconds: seconds, pm: pm};
    end
  end

  always_comb begin
    nibble = snap_nxt.hours[7:4];
    an_sel = AN_OFF;
    case (dig_nxt)
      3'd0: begin nibble = snap_nxt.seconds[3:0]; an_sel = 6'b111110; end
      3'd1: begin nibble = snap_nxt.seconds[7:4]; an_sel = 6'b111101; end
      3'd2: begin nibble = snap_nxt.minutes[3:0]; an_sel = 6'b111011; end
      3'd3: begin nibble = snap_nxt.minutes[7:4]; an_sel = 6'b110111; end
      3'd4: begin nibble = snap_nxt.hours[3:0];   an_sel = 6'b101111; end
      3'd5: begin nibble = snap_nxt.hours[7:4];   an_sel = 6'b011111; end
      default: begin nibble = 4'd0;               an_sel = AN_OFF;    end
    endcase
  end

  assign blank = (dig_nxt == DIG_LAST) && (nibble == 4'd0);

  bcd_seg_decode u_decode (
    .nibble (nibble),
    .blank  (blank),
    .seg_n  (seg_nxt)
  );

  always_comb begin
    dp_nxt = 1'b1;
    if ((dig_nxt == 3'd2 || dig_nxt == 3'd4) && !snap_nxt.seconds[0]) dp_nxt = 1'b0;
    if (dig_nxt == 3'd0 && snap_nxt.pm) dp_nxt = 1'b0;
  end

`ifdef DISP_DIM_EN
  // Tested as div*8 - SCAN_DIV < bright*SCAN_DIV so no operand reaches 8*SCAN_DIV.
  localparam int CMP_W = DIV_W + 3;
  localparam logic [CMP_W-1:0] SCAN_DIV_C = CMP_W'(SCAN_DIV);

  logic [CMP_W-1:0] div_x8;
  logic [CMP_W-1:0] on_scaled;

  assign div_x8    = {div_nxt, 3'b000};
  assign on_scaled = CMP_W'(bright) * SCAN_DIV_C;
  assign pwm_on    = (div_x8 < SCAN_DIV_C) || ((div_x8 - SCAN_DIV_C) < on_scaled);
`else
  assign pwm_on = 1'b1;
`endif

  assign an_nxt = ((div_nxt != '0) && pwm_on) ? an_sel : AN_OFF;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      dig     <= DIG_FIRST;
      snap    <= '0;
      primed  <= 1'b0;
      seg_n   <= SEG_BLANK;
      dp_n    <= 1'b1;
      an_n    <= AN_OFF;
    end else begin
      div_cnt <= div_nxt;
      dig     <= dig_nxt;
      snap    <= snap_nxt;
      primed  <= 1'b1;
      seg_n   <= seg_nxt;
      dp_n    <= dp_nxt;
      an_n    <= an_nxt;
    end
  end

endmodule

`default_nettype wire
